// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op classes, funct codes, ALU commands and PC constants
package alu_pkg;
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_RTYPE = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_LUI   = 4'b0111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  typedef enum logic [3:0] {
    CMD_AND  = 4'b0000,
    CMD_OR   = 4'b0001,
    CMD_ADD  = 4'b0010,
    CMD_XOR  = 4'b0011,
    CMD_NOR  = 4'b0100,
    CMD_LUI  = 4'b0101,
    CMD_SUB  = 4'b0110,
    CMD_SLT  = 4'b0111,
    CMD_SLL  = 4'b1000,
    CMD_SRL  = 4'b1001,
    CMD_SRA  = 4'b1010,
    CMD_SLTU = 4'b1011
  } alu_cmd_e;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the control unit's alu_op class and R-type funct to an ALU command
module alu_decoder
  import alu_pkg::*;
(
  input  logic [3:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_cmd
);
  alu_cmd_e fcmd, cmd;
  always_comb begin
    fcmd = CMD_ADD;
    case (funct)
      F_ADD, F_ADDU: fcmd = CMD_ADD;
      F_SUB, F_SUBU: fcmd = CMD_SUB;
      F_AND:         fcmd = CMD_AND;
      F_OR:          fcmd = CMD_OR;
      F_XOR:         fcmd = CMD_XOR;
      F_NOR:         fcmd = CMD_NOR;
      F_SLT:         fcmd = CMD_SLT;
      F_SLTU:        fcmd = CMD_SLTU;
      F_SLL:         fcmd = CMD_SLL;
      F_SRL:         fcmd = CMD_SRL;
      F_SRA:         fcmd = CMD_SRA;
      default:       fcmd = CMD_ADD;
    endcase
    cmd = CMD_ADD;
    case (alu_op)
      OP_SUB:   cmd = CMD_SUB;
      OP_RTYPE: cmd = fcmd;
      OP_AND:   cmd = CMD_AND;
      OP_OR:    cmd = CMD_OR;
      OP_SLT:   cmd = CMD_SLT;
      OP_XOR:   cmd = CMD_XOR;
      OP_LUI:   cmd = CMD_LUI;
      default:  cmd = CMD_ADD;
    endcase
  end
  assign alu_cmd = cmd;
endmodule

// File: rtl/pc_alu_unit.sv
// pc_alu_unit: program counter register plus decoded 32-bit integer ALU for the EX stage
module pc_alu_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_hold,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic [31:0] pc,
  input  logic [3:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] oper1,
  input  logic [31:0] oper2,
  output logic [3:0]  alu_cmd,
  output logic [31:0] result,
  output logic        overflow,
  output logic        zero
);
  alu_cmd_e cmd;
  logic [31:0] sum, diff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= PC_RESET;
    else if (pc_load) pc <= pc_target;
    else if (!pc_hold) pc <= pc + PC_INC;
  alu_decoder u_dec (
    .alu_op  (alu_op),
    .funct   (funct),
    .alu_cmd (alu_cmd)
  );
  assign cmd  = alu_cmd_e'(alu_cmd);
  assign sum  = oper1 + oper2;
  assign diff = oper1 - oper2;
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (cmd)
      CMD_AND:  result = oper1 & oper2;
      CMD_OR:   result = oper1 | oper2;
      CMD_XOR:  result = oper1 ^ oper2;
      CMD_NOR:  result = ~(oper1 | oper2);
      CMD_LUI:  result = {oper2[15:0], 16'h0};
      CMD_ADD: begin
        result   = sum;
        overflow = (oper1[31] == oper2[31]) && (sum[31] != oper1[31]);
      end
      CMD_SUB: begin
        result   = diff;
        overflow = (oper1[31] != oper2[31]) && (diff[31] != oper1[31]);
      end
      CMD_SLT:  result = {31'b0, $signed(oper1) < $signed(oper2)};
      CMD_SLTU: result = {31'b0, oper1 < oper2};
      CMD_SLL:  result = oper2 << shamt;
      CMD_SRL:  result = oper2 >> shamt;
      CMD_SRA:  result = $signed(oper2) >>> shamt;
      default:  result = '0;
    endcase
  end
  assign zero = result == '0;
endmodule

// File: tb/tb_pc_alu_unit.sv
// tb_pc_alu_unit: directed vectors with a spec-level model checked every cycle
module tb_pc_alu_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_hold = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_target = '0;
  logic [31:0] pc;
  logic [3:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] oper1 = '0;
  logic [31:0] oper2 = '0;
  logic [3:0]  alu_cmd;
  logic [31:0] result;
  logic        overflow;
  logic        zero;
  logic [31:0] exp_pc = '0;
  int checks = 0;
  int errors = 0;

  pc_alu_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_hold(pc_hold), .pc_load(pc_load),
    .pc_target(pc_target), .pc(pc), .alu_op(alu_op), .funct(funct),
    .shamt(shamt), .oper1(oper1), .oper2(oper2), .alu_cmd(alu_cmd),
    .result(result), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Expected PC: reset clears, redirect beats stall, otherwise step one word
  always @(posedge clk or negedge rst_n)
    if (!rst_n) exp_pc <= 32'h0;
    else if (pc_load) exp_pc <= pc_target;
    else if (!pc_hold) exp_pc <= 32'((64'(exp_pc) + 64'd4) % 64'h1_0000_0000);

  function automatic logic [3:0] model_cmd(input logic [3:0] op, input logic [5:0] f);
    logic [3:0] ops [8] = '{4'd2, 4'd6, 4'd0, 4'd0, 4'd1, 4'd7, 4'd3, 4'd5};
    if (op > 4'd7) return 4'd2;
    if (op != 4'd2) return ops[op];
    case (f)
      6'd32, 6'd33: return 4'd2;
      6'd34, 6'd35: return 4'd6;
      6'd36: return 4'd0;
      6'd37: return 4'd1;
      6'd38: return 4'd3;
      6'd39: return 4'd4;
      6'd42: return 4'd7;
      6'd43: return 4'd11;
      6'd0:  return 4'd8;
      6'd2:  return 4'd9;
      6'd3:  return 4'd10;
      default: return 4'd2;
    endcase
  endfunction

  // Returns {overflow, result}; overflow from exact wide signed arithmetic
  function automatic logic [32:0] model_alu(input logic [3:0] c, input logic [4:0] sh,
                                           input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint w;
    logic [31:0] r = '0;
    case (c)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd3: r = a ^ b;
      4'd4: r = ~(a | b);
      4'd5: r = b * 32'h1_0000;
      4'd2: begin w = sa + sb; return {w > 64'sd2147483647 || w < -64'sd2147483648, w[31:0]}; end
      4'd6: begin w = sa - sb; return {w > 64'sd2147483647 || w < -64'sd2147483648, w[31:0]}; end
      4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd11: r = ({32'b0, a} < {32'b0, b}) ? 32'd1 : 32'd0;
      4'd8: r = 32'(64'(b) * (64'd1 << sh));
      4'd9: r = 32'(64'(b) / (64'd1 << sh));
      4'd10: begin
        w = sb;
        for (int i = 0; i < int'(sh); i++) w = (w < 0) ? -((-w + 1) / 2) : w / 2;
        r = w[31:0];
      end
      default: r = '0;
    endcase
    return {1'b0, r};
  endfunction

  always @(negedge clk) begin
    logic [3:0] c;
    logic [32:0] m;
    c = model_cmd(alu_op, funct);
    m = model_alu(c, shamt, oper1, oper2);
    chk("pc_model", pc, exp_pc);
    chk("cmd_model", {28'b0, alu_cmd}, {28'b0, c});
    chk("result_model", result, m[31:0]);
    chk("ovf_model", {31'b0, overflow}, {31'b0, m[32]});
    chk("zero_model", {31'b0, zero}, {31'b0, m[31:0] == 32'h0});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input logic [3:0] op, input logic [5:0] f,
                     input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] want_cmd, input logic [31:0] want_res, input logic want_ovf);
    alu_op = op; funct = f; shamt = sh; oper1 = a; oper2 = b;
    #1;
    chk({name, "_res"}, result, want_res);
    chk({name, "_cmd"}, {28'b0, alu_cmd}, {28'b0, want_cmd});
    chk({name, "_ovf"}, {31'b0, overflow}, {31'b0, want_ovf});
    chk({name, "_zero"}, {31'b0, zero}, {31'b0, want_res == 32'h0});
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2 chk("reset_no_clk", pc, 32'h0);
    tick();
    rst_n = 1'b1;
    tick(); chk("inc1", pc, 32'h4);
    tick(); chk("inc2", pc, 32'h8);
    tick(); chk("inc3", pc, 32'hC);
    pc_hold = 1'b1;
    tick(); chk("hold1", pc, 32'hC);
    tick(); chk("hold2", pc, 32'hC);
    pc_load = 1'b1; pc_target = 32'h40;
    tick(); chk("load_over_hold", pc, 32'h40);
    pc_hold = 1'b0; pc_target = 32'hFFFF_FFFC;
    tick(); chk("load_top", pc, 32'hFFFF_FFFC);
    pc_load = 1'b0;
    tick(); chk("wrap", pc, 32'h0);
    tick(); chk("after_wrap", pc, 32'h4);
    pc_load = 1'b1; pc_target = 32'h80;
    #2 rst_n = 1'b0;
    #1 chk("async_reset", pc, 32'h0);
    tick(); chk("reset_beats_load", pc, 32'h0);
    rst_n = 1'b1; pc_load = 1'b0;
    tick(); chk("post_reset", pc, 32'h4);
    pc_hold = 1'b1;
    run("add_ovf", 4'b0010, 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'h1, 4'b0010, 32'h8000_0000, 1'b1);
    run("sub_zero", 4'b0010, 6'b100010, 5'd0, 32'd5, 32'd5, 4'b0110, 32'h0, 1'b0);
    run("sub_ovf", 4'b0010, 6'b100011, 5'd0, 32'h8000_0000, 32'h1, 4'b0110, 32'h7FFF_FFFF, 1'b1);
    run("and", 4'b0010, 6'b100100, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 32'hF000_F000, 1'b0);
    run("or", 4'b0010, 6'b100101, 5'd0, 32'hF0F0_0000, 32'h0000_0F0F, 4'b0001, 32'hF0F0_0F0F, 1'b0);
    run("xor", 4'b0010, 6'b100110, 5'd0, 32'hFFFF_0000, 32'hFF00_FF00, 4'b0011, 32'h00FF_FF00, 1'b0);
    run("nor", 4'b0010, 6'b100111, 5'd0, 32'h0, 32'h0, 4'b0100, 32'hFFFF_FFFF, 1'b0);
    run("slt", 4'b0010, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'h1, 4'b0111, 32'h1, 1'b0);
    run("sltu", 4'b0010, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'h1, 4'b1011, 32'h0, 1'b0);
    run("sll", 4'b0010, 6'b000000, 5'd31, 32'h0, 32'h1, 4'b1000, 32'h8000_0000, 1'b0);
    run("sra", 4'b0010, 6'b000011, 5'd4, 32'h0, 32'h8000_0000, 4'b1010, 32'hF800_0000, 1'b0);
    run("srl", 4'b0010, 6'b000010, 5'd4, 32'h0, 32'h8000_0000, 4'b1001, 32'h0800_0000, 1'b0);
    run("op_add", 4'b0000, 6'b100010, 5'd0, 32'd3, 32'd4, 4'b0010, 32'd7, 1'b0);
    run("op_sub", 4'b0001, 6'b100000, 5'd0, 32'd9, 32'd4, 4'b0110, 32'd5, 1'b0);
    run("op_andi", 4'b0011, 6'b0, 5'd0, 32'h0000_FF0F, 32'h0000_0FF0, 4'b0000, 32'h0000_0F00, 1'b0);
    run("op_ori", 4'b0100, 6'b0, 5'd0, 32'h0000_1200, 32'h0000_0034, 4'b0001, 32'h0000_1234, 1'b0);
    run("op_slti", 4'b0101, 6'b0, 5'd0, 32'd5, 32'hFFFF_FFFE, 4'b0111, 32'h0, 1'b0);
    run("op_xori", 4'b0110, 6'b0, 5'd0, 32'h0000_00FF, 32'h0000_0F0F, 4'b0011, 32'h0000_0FF0, 1'b0);
    run("op_lui", 4'b0111, 6'b0, 5'd0, 32'h0, 32'h0000_1234, 4'b0101, 32'h1234_0000, 1'b0);
    run("bad_funct", 4'b0010, 6'b111111, 5'd0, 32'd1, 32'd2, 4'b0010, 32'd3, 1'b0);
    run("bad_op", 4'b1111, 6'b100010, 5'd0, 32'd10, 32'd20, 4'b0010, 32'd30, 1'b0);
    run("add_neg_ovf", 4'b0000, 6'b0, 5'd0, 32'h8000_0000, 32'h8000_0000, 4'b0010, 32'h0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
